subshift: RTL and testbench
===========================

// Module: subshift
// PURPOSE
// - AES SubBytes + ShiftRows round stage; sits directly upstream of mixcol on the shared state SRAM.
// - On enable: reads the 128-bit state word, substitutes every byte through the AES S-box LANES bytes per cycle,
//   applies ShiftRows, writes the result back to the same address, then pulses finished so the controller starts mixcol.
// - State word layout (same as mixcol): byte (row r, col c) at bits [127-8*(4c+r) -: 8], column-major.
// PARAMETERS
// - STATE_ADDR  16'd32  SRAM address of the state word (read and write)
// - RD_WAIT     2       cycles from the read-strobe cycle to the capture edge; legal 1..4
// - LANES       1       S-box instances / bytes substituted per cycle; legal 1,2,4,8,16
// PORTS
// - clk             in   1    clock, all logic on rising edge
// - rst             in   1    synchronous, active-high reset
// - subshift_enable in   1    start request, sampled only in IDLE
// - sramReadValue   in   128  SRAM read data
// - sramWriteValue  out  128  result word, valid while sramWrite=1
// - sramRead        out  1    read strobe
// - sramWrite       out  1    write strobe
// - sramAddr        out  16   SRAM address
// - subshift_finished out 1   one-cycle done pulse (registered)
// BEHAVIOUR
// - Reset (sync, rst=1 at edge): state=IDLE, byte counter=0, data reg=0, subshift_finished=0; all strobes 0, sramAddr=0.
//   rst wins over every other event; reset mid-operation aborts with no write issued.
// - FSM: IDLE -> SETADDR -> READ -> WAIT -> CAPTURE -> SUB -> WRADDR -> WRITE -> DONE -> IDLE.
//   - IDLE: all outputs 0; subshift_enable=1 at edge -> SETADDR. enable outside IDLE is ignored (no queueing).
//   - SETADDR: sramAddr=STATE_ADDR.  READ: sramAddr=STATE_ADDR, sramRead=1 (exactly one cycle).
//   - WAIT: RD_WAIT-1 cycles (skipped when RD_WAIT=1), counter-driven.
//   - CAPTURE: sramReadValue registered into data reg at the edge ending this cycle (RD_WAIT cycles after READ).
//   - SUB: 16/LANES cycles; each cycle replaces LANES bytes of data reg, lowest byte index first
//     (byte index i = 4c+r); counter wraps to 0 on last group and FSM advances.
//   - WRADDR: sramAddr=STATE_ADDR.  WRITE: sramAddr=STATE_ADDR, sramWrite=1 (one cycle).
//   - DONE: subshift_finished=1 for exactly this cycle; next state IDLE.
// - sramWriteValue = ShiftRows(data reg): out(r,c)=sub(r,(c+r) mod 4); combinational from data reg,
//   held stable through WRADDR/WRITE; 0 from reset until first CAPTURE.
// - S-box: combinational function (GF(2^8) inverse mod x^8+x^4+x^3+x+1, then affine 0x63); 8-bit in/out, no truncation.
// - Latency: enable sampled at edge k -> finished high in cycle k + 5 + RD_WAIT + 16/LANES (23 at defaults).
// - enable held high continuously: one pass per IDLE visit; next pass starts the cycle after DONE.
// - sramRead and sramWrite never both 1; never asserted outside READ/WRITE.
// CONFIGURATION
// - INV_SUBSHIFT_EN defined: extra input port `inverse` (1 bit), sampled in IDLE with enable and held for the pass;
//   inverse=1 selects InvSubBytes (inverse affine then GF inverse) + InvShiftRows out(r,c)=sub(r,(c-r) mod 4).
//   inverse=0 behaves exactly as forward mode.
// - INV_SUBSHIFT_EN undefined: no `inverse` port, forward-only logic, no inverse S-box hardware.
// TESTING
// - FIPS-197 App.B: read 193de3bea0f4e22b9ac68d2ae9f84808 -> single write of d4bf5d30e0b452aeb84111f11e2798e5, finished 23 cycles after enable.
// - All-zero word -> writes 63636363636363636363636363636363; byte 0x53 at (0,0), rest 0x00 -> write 0xED at (0,0), 0x63 elsewhere.
// - LANES=4, RD_WAIT=1: FIPS vector gives same result, finished at k+10; sramRead exactly one cycle, capture edge right after it.
// - Pulse enable again during SUB -> ignored, exactly one write; enable held high -> back-to-back passes, DONE->SETADDR gap of one IDLE cycle.
// - Assert rst during SUB -> next cycle IDLE, finished=0, no sramWrite ever issued for that pass; new enable completes normally.
// - INV_SUBSHIFT_EN, inverse=1: read d4bf5d30e0b452aeb84111f11e2798e5 -> write 193de3bea0f4e22b9ac68d2ae9f84808.

Source files
------------

// File: rtl/subshift.sv
// AES SubBytes+ShiftRows stage on the shared state SRAM: read, substitute LANES bytes/cycle, write back, pulse done.
// Latency 5+RD_WAIT+16/LANES cycles; no backpressure. INV_SUBSHIFT_EN adds the `inverse` port.
module subshift #(
  parameter logic [15:0] STATE_ADDR = 16'd32,
  parameter int          RD_WAIT    = 2,
  parameter int          LANES      = 1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef INV_SUBSHIFT_EN
  input  logic         inverse,
`endif
  input  logic         subshift_enable,
  input  logic [127:0] sramReadValue,
  output logic [127:0] sramWriteValue,
  output logic         sramRead,
  output logic         sramWrite,
  output logic [15:0]  sramAddr,
  output logic         subshift_finished
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETADDR, S_READ, S_WAIT, S_CAPTURE, S_SUB, S_WRADDR, S_WRITE, S_DONE
  } state_t;

  localparam int          GROUPS    = 16 / LANES;
  localparam logic [3:0]  SUB_LAST  = 4'(GROUPS - 1);
  localparam logic [3:0]  WAIT_LAST = 4'((RD_WAIT > 1) ? (RD_WAIT - 2) : 0);
  localparam logic [7:0]  AFF_C     = 8'h63;

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] data;
  logic [127:0] data_sub;
  logic [7:0]   sb_in  [LANES];
  logic [7:0]   sb_out [LANES];
`ifdef INV_SUBSHIFT_EN
  logic         inv_q;
  localparam logic [7:0] INV_AFF_C = 8'h05;
`endif

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] r;
    t = gf_mul(a, a);
    r = t;
    for (int i = 0; i < 6; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] v;
    logic [7:0] b;
    v = gf_inv(a);
    for (int i = 0; i < 8; i++)
      b[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ AFF_C[i];
    return b;
  endfunction

`ifdef INV_SUBSHIFT_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    for (int i = 0; i < 8; i++)
      b[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8] ^ INV_AFF_C[i];
    return gf_inv(b);
  endfunction
`endif

  always_comb begin
    for (int l = 0; l < LANES; l++) sb_in[l] = 8'h00;
    for (int g = 0; g < GROUPS; g++)
      if (cnt == 4'(g))
        for (int l = 0; l < LANES; l++)
          sb_in[l] = data[127 - 8 * (g * LANES + l) -: 8];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef INV_SUBSHIFT_EN
    assign sb_out[l] = inv_q ? inv_sbox(sb_in[l]) : fwd_sbox(sb_in[l]);
`else
    assign sb_out[l] = fwd_sbox(sb_in[l]);
`endif
  end

  always_comb begin
    data_sub = data;
    for (int g = 0; g < GROUPS; g++)
      if (cnt == 4'(g))
        for (int l = 0; l < LANES; l++)
          data_sub[127 - 8 * (g * LANES + l) -: 8] = sb_out[l];
  end

  // Row r rotates left by r columns (right by r in inverse mode)
  always_comb begin
    sramWriteValue = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
`ifdef INV_SUBSHIFT_EN
        if (inv_q)
          sramWriteValue[127 - 8 * (4 * c + r) -: 8] = data[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
        else
          sramWriteValue[127 - 8 * (4 * c + r) -: 8] = data[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
`else
        sramWriteValue[127 - 8 * (4 * c + r) -: 8] = data[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
`endif
      end
  end

  // Outputs are registered for the state being entered, so they line up with that state's cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      cnt               <= '0;
      data              <= '0;
      subshift_finished <= 1'b0;
      sramRead          <= 1'b0;
      sramWrite         <= 1'b0;
      sramAddr          <= '0;
`ifdef INV_SUBSHIFT_EN
      inv_q             <= 1'b0;
`endif
    end else begin
      sramRead          <= 1'b0;
      sramWrite         <= 1'b0;
      subshift_finished <= 1'b0;
      sramAddr          <= '0;
      case (state)
        S_IDLE: begin
          if (subshift_enable) begin
            state    <= S_SETADDR;
            sramAddr <= STATE_ADDR;
`ifdef INV_SUBSHIFT_EN
            inv_q    <= inverse;
`endif
          end
        end
        S_SETADDR: begin
          state    <= S_READ;
          sramAddr <= STATE_ADDR;
          sramRead <= 1'b1;
        end
        S_READ: begin
          cnt   <= '0;
          state <= (RD_WAIT > 1) ? S_WAIT : S_CAPTURE;
        end
        S_WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt   <= '0;
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_CAPTURE: begin
          data  <= sramReadValue;
          cnt   <= '0;
          state <= S_SUB;
        end
        S_SUB: begin
          data <= data_sub;
          if (cnt == SUB_LAST) begin
            cnt      <= '0;
            state    <= S_WRADDR;
            sramAddr <= STATE_ADDR;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_WRADDR: begin
          state     <= S_WRITE;
          sramAddr  <= STATE_ADDR;
          sramWrite <= 1'b1;
        end
        S_WRITE: begin
          state             <= S_DONE;
          subshift_finished <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subshift.sv
// Bench for subshift: two instances (default and LANES=4/RD_WAIT=1) against an SRAM responder and scoreboard.
// Read data is only presented in the exact capture cycle; other cycles carry a junk pattern.
module tb_subshift;

  localparam logic [15:0]  ADDR      = 16'd32;
  localparam int           RDW0      = 2;
  localparam int           LN0       = 1;
  localparam int           RDW1      = 1;
  localparam int           LN1       = 4;
  localparam int           LAT0      = 5 + RDW0 + 16 / LN0;
  localparam int           LAT1      = 5 + RDW1 + 16 / LN1;
  localparam logic [127:0] JUNK      = 128'hdeadbeef_0badf00d_5a5aa5a5_c3c33c3c;
  localparam logic [127:0] FIPS_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  logic         clk = 1'b0;
  logic         rst;
  logic         en   [2];
  logic [127:0] rv   [2];
  logic [127:0] wv   [2];
  logic         rd   [2];
  logic         wr   [2];
  logic         fin  [2];
  logic [15:0]  addr [2];
`ifdef INV_SUBSHIFT_EN
  logic         inv  [2];
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat     [2] = '{LAT0, LAT1};
  int rdw     [2] = '{RDW0, RDW1};
  logic [127:0] mem [2];
  int rd_age  [2] = '{-1, -1};
  int wr_cnt  [2] = '{0, 0};
  int rd_cnt  [2] = '{0, 0};
  int fin_cnt [2] = '{0, 0};
  int fin_cyc [2] = '{0, 0};
  logic [127:0] exp_q0[$];
  logic [127:0] exp_q1[$];

  always #5 clk = ~clk;

  subshift #(.STATE_ADDR(ADDR), .RD_WAIT(RDW0), .LANES(LN0)) u_dut0 (
    .clk(clk), .rst(rst),
`ifdef INV_SUBSHIFT_EN
    .inverse(inv[0]),
`endif
    .subshift_enable(en[0]), .sramReadValue(rv[0]), .sramWriteValue(wv[0]),
    .sramRead(rd[0]), .sramWrite(wr[0]), .sramAddr(addr[0]), .subshift_finished(fin[0])
  );

  subshift #(.STATE_ADDR(ADDR), .RD_WAIT(RDW1), .LANES(LN1)) u_dut1 (
    .clk(clk), .rst(rst),
`ifdef INV_SUBSHIFT_EN
    .inverse(inv[1]),
`endif
    .subshift_enable(en[1]), .sramReadValue(rv[1]), .sramWriteValue(wv[1]),
    .sramRead(rd[1]), .sramWrite(wr[1]), .sramAddr(addr[1]), .subshift_finished(fin[1])
  );

  // Reference S-box: exhaustive inverse search and rotate-form affine maps
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) p ^= bb;
      bb = bb[7] ? ((bb << 1) ^ 8'h1b) : (bb << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_inv(input logic [7:0] x);
    logic [7:0] y = 8'h00;
    for (int k = 1; k < 256; k++)
      if (m_mul(x, 8'(k)) == 8'h01) y = 8'(k);
    return y;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] m_box(input logic [7:0] x, input bit inv_mode);
    logic [7:0] v;
    if (!inv_mode) begin
      v = m_inv(x);
      return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    end
    v = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
    return m_inv(v);
  endfunction

  function automatic logic [127:0] model(input logic [127:0] din, input bit inv_mode);
    logic [127:0] o = '0;
    int sc;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        sc = inv_mode ? (c - r + 4) % 4 : (c + r) % 4;
        o[127 - 8 * (4 * c + r) -: 8] = m_box(din[127 - 8 * (4 * sc + r) -: 8], inv_mode);
      end
    return o;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SRAM responder + write scoreboard
  initial begin : mon
    logic [127:0] e;
    bit has;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rd[d] === 1'b1 || wr[d] === 1'b1) begin
          checks++;
          if (rd[d] === 1'b1 && wr[d] === 1'b1) begin
            errors++;
            $display("FAIL strobe_excl[%0d]: read=%b write=%b, required not both", d, rd[d], wr[d]);
          end
          checks++;
          if (addr[d] !== ADDR) begin
            errors++;
            $display("FAIL strobe_addr[%0d]: got %h required %h", d, addr[d], ADDR);
          end
        end
        if (rd[d] === 1'b1) begin
          rd_cnt[d]++;
          rd_age[d] = 0;
        end else if (rd_age[d] >= 0) begin
          rd_age[d] = (rd_age[d] > 8) ? -1 : rd_age[d] + 1;
        end
        rv[d] = (rd_age[d] == rdw[d]) ? mem[d] : JUNK;
        if (wr[d] === 1'b1) begin
          wr_cnt[d]++;
          has = 1'b0;
          e   = '0;
          if (d == 0 && exp_q0.size() > 0) begin has = 1'b1; e = exp_q0.pop_front(); end
          if (d == 1 && exp_q1.size() > 0) begin has = 1'b1; e = exp_q1.pop_front(); end
          checks++;
          if (!has) begin
            errors++;
            $display("FAIL write_unexpected[%0d]: got %h, required no write", d, wv[d]);
          end else if (wv[d] !== e) begin
            errors++;
            $display("FAIL write_data[%0d]: got %h required %h", d, wv[d], e);
          end
        end
        if (fin[d] === 1'b1) begin
          fin_cnt[d]++;
          fin_cyc[d] = cyc;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (fin[d] !== 1'b0) begin errors++; $display("FAIL reset_fin[%0d]: got %b required 0", d, fin[d]); end
      checks++;
      if (rd[d] !== 1'b0 || wr[d] !== 1'b0) begin
        errors++; $display("FAIL reset_strobes[%0d]: rd=%b wr=%b required 0 0", d, rd[d], wr[d]);
      end
      checks++;
      if (addr[d] !== 16'h0) begin errors++; $display("FAIL reset_addr[%0d]: got %h required 0", d, addr[d]); end
      checks++;
      if (wv[d] !== 128'h0) begin errors++; $display("FAIL reset_wdata[%0d]: got %h required 0", d, wv[d]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors(input bit inv_mode);
    logic [127:0] din [6];
    logic [127:0] expv[6];
    int s, w0[2], r0[2], f0[2];
    bit ok;
    if (!inv_mode) begin
      din[0] = FIPS_IN;             expv[0] = FIPS_OUT;
      din[1] = '0;                  expv[1] = {16{8'h63}};
      din[2] = {8'h53, 120'h0};     expv[2] = {8'hed, {15{8'h63}}};
    end else begin
      din[0] = FIPS_OUT;            expv[0] = FIPS_IN;
      din[1] = {16{8'h63}};         expv[1] = '0;
      din[2] = {8'hed, {15{8'h63}}}; expv[2] = {8'h53, 120'h0};
    end
    for (int k = 3; k < 6; k++) begin
      din[k]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      expv[k] = model(din[k], inv_mode);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        mem[d] = din[k]; w0[d] = wr_cnt[d]; r0[d] = rd_cnt[d]; f0[d] = fin_cnt[d];
`ifdef INV_SUBSHIFT_EN
        inv[d] = inv_mode;
`endif
        en[d] = 1'b1;
      end
      exp_q0.push_back(expv[k]);
      exp_q1.push_back(expv[k]);
      s = cyc;
      @(negedge clk);
      en[0] = 1'b0; en[1] = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(posedge clk);
        ok = (fin_cnt[0] > f0[0]) && (fin_cnt[1] > f0[1]);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (!ok) begin errors++; $display("FAIL vec%0d_timeout: finished not seen, required within 100 cycles", k); end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (fin_cyc[d] - s != lat[d]) begin
          errors++; $display("FAIL vec%0d_latency[%0d]: got %0d required %0d", k, d, fin_cyc[d] - s, lat[d]);
        end
        checks++;
        if (wr_cnt[d] - w0[d] != 1) begin
          errors++; $display("FAIL vec%0d_writes[%0d]: got %0d required 1", k, d, wr_cnt[d] - w0[d]);
        end
        checks++;
        if (rd_cnt[d] - r0[d] != 1) begin
          errors++; $display("FAIL vec%0d_reads[%0d]: got %0d required 1", k, d, rd_cnt[d] - r0[d]);
        end
      end
    end
  endtask

  task automatic test_enable_during_sub();
    logic [127:0] din;
    int w0[2], f0[2];
    din = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      mem[d] = din; w0[d] = wr_cnt[d]; f0[d] = fin_cnt[d]; en[d] = 1'b1;
    end
    exp_q0.push_back(model(din, 1'b0));
    exp_q1.push_back(model(din, 1'b0));
    @(negedge clk);
    en[0] = 1'b0; en[1] = 1'b0;
    repeat (5) @(negedge clk);
    en[0] = 1'b1; en[1] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0; en[1] = 1'b0;
    repeat (60) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (wr_cnt[d] - w0[d] != 1) begin
        errors++; $display("FAIL ignore_en_writes[%0d]: got %0d required 1", d, wr_cnt[d] - w0[d]);
      end
      checks++;
      if (fin_cnt[d] - f0[d] != 1) begin
        errors++; $display("FAIL ignore_en_finished[%0d]: got %0d required 1", d, fin_cnt[d] - f0[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] din;
    int w0[2], hits[2], f1[2], f2[2];
    din = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      mem[d] = din; w0[d] = wr_cnt[d]; hits[d] = 0; f1[d] = 0; f2[d] = 0; en[d] = 1'b1;
    end
    repeat (2) begin
      exp_q0.push_back(model(din, 1'b0));
      exp_q1.push_back(model(din, 1'b0));
    end
    for (int i = 0; i < 200 && (en[0] || en[1]); i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (en[d] && fin[d] === 1'b1) begin
          hits[d]++;
          if (hits[d] == 1) f1[d] = cyc;
          else begin f2[d] = cyc; en[d] = 1'b0; end
        end
    end
    checks++;
    if (en[0] || en[1]) begin
      errors++; $display("FAIL b2b_timeout: passes %0d/%0d, required 2/2", hits[0], hits[1]);
      en[0] = 1'b0; en[1] = 1'b0;
    end
    repeat (40) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (f2[d] - f1[d] != lat[d] + 1) begin
        errors++; $display("FAIL b2b_period[%0d]: got %0d required %0d", d, f2[d] - f1[d], lat[d] + 1);
      end
      checks++;
      if (wr_cnt[d] - w0[d] != 2) begin
        errors++; $display("FAIL b2b_writes[%0d]: got %0d required 2", d, wr_cnt[d] - w0[d]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w0[2], f0[2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      mem[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
      w0[d] = wr_cnt[d]; f0[d] = fin_cnt[d]; en[d] = 1'b1;
    end
    @(negedge clk);
    en[0] = 1'b0; en[1] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (fin[d] !== 1'b0 || wr[d] !== 1'b0 || rd[d] !== 1'b0) begin
        errors++; $display("FAIL midrst_outputs[%0d]: fin=%b wr=%b rd=%b required 0 0 0", d, fin[d], wr[d], rd[d]);
      end
      checks++;
      if (wv[d] !== 128'h0) begin errors++; $display("FAIL midrst_wdata[%0d]: got %h required 0", d, wv[d]); end
    end
    repeat (40) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (wr_cnt[d] != w0[d] || fin_cnt[d] != f0[d]) begin
        errors++;
        $display("FAIL midrst_aborted[%0d]: writes %0d finished %0d, required 0 0", d, wr_cnt[d] - w0[d], fin_cnt[d] - f0[d]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; rv[d] = JUNK; mem[d] = '0;
`ifdef INV_SUBSHIFT_EN
      inv[d] = 1'b0;
`endif
    end
    test_reset();
    test_reset_mid();
    test_vectors(1'b0);
    test_enable_during_sub();
    test_back_to_back();
`ifdef INV_SUBSHIFT_EN
    test_vectors(1'b1);
    test_vectors(1'b0);
`endif
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
